// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM bus to one of the init, refresh, write or read engines at a time
// Ports: sys_clk, sys_rst (sync, active-low); per-engine cmd/ba/addr buses plus req/end handshakes;
//        aref_en/wr_en/rd_en grants; sdram_* command, address and DQ output pins.
// Option: SDRAM_ARB_RR_EN alternates write/read when both are pending; otherwise write beats read.
module sdram_arbit (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  write_cmd,
    input  logic [1:0]  write_ba,
    input  logic [12:0] write_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  read_cmd,
    input  logic [1:0]  read_ba,
    input  logic [12:0] read_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);
    typedef enum logic [2:0] {ARB_IDLE, ARB_ARBIT, ARB_AREF, ARB_WRITE, ARB_READ} state_t;
    state_t state, state_nxt;
    logic [3:0] cmd;
    logic       wr_pick;

`ifdef SDRAM_ARB_RR_EN
    // last_rd: 1 when read was the most recently granted burst; reset favours write first
    logic last_rd;
    always_ff @(posedge sys_clk) begin
        if (!sys_rst)
            last_rd <= 1'b1;
        else if (state == ARB_ARBIT && state_nxt == ARB_WRITE)
            last_rd <= 1'b0;
        else if (state == ARB_ARBIT && state_nxt == ARB_READ)
            last_rd <= 1'b1;
    end
    assign wr_pick = wr_req && (!rd_req || last_rd);
`else
    assign wr_pick = wr_req;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst)
            state <= ARB_IDLE;
        else
            state <= state_nxt;
    end

    // Refresh is only considered from ARB_ARBIT, so it never cuts a burst short
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  state_nxt = init_end ? ARB_ARBIT : ARB_IDLE;
            ARB_ARBIT: state_nxt = aref_req ? ARB_AREF :
                                   wr_pick  ? ARB_WRITE :
                                   rd_req   ? ARB_READ : ARB_ARBIT;
            ARB_AREF:  state_nxt = aref_end ? ARB_ARBIT : ARB_AREF;
            ARB_WRITE: state_nxt = wr_end ? ARB_ARBIT : ARB_WRITE;
            ARB_READ:  state_nxt = rd_end ? ARB_ARBIT : ARB_READ;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Pin mux is purely combinational from state so engine registers reach the pins with no added delay
    always_comb begin
        aref_en = state == ARB_AREF;
        wr_en   = state == ARB_WRITE;
        rd_en   = state == ARB_READ;
        {cmd, sdram_ba, sdram_addr} = {init_cmd, init_ba, init_addr};
        case (state)
            ARB_ARBIT: {cmd, sdram_ba, sdram_addr} = {4'b0111, 2'b11, 13'h1FFF};
            ARB_AREF:  {cmd, sdram_ba, sdram_addr} = {aref_cmd, aref_ba, aref_addr};
            ARB_WRITE: {cmd, sdram_ba, sdram_addr} = {write_cmd, write_ba, write_addr};
            ARB_READ:  {cmd, sdram_ba, sdram_addr} = {read_cmd, read_ba, read_addr};
            default:   {cmd, sdram_ba, sdram_addr} = {init_cmd, init_ba, init_addr};
        endcase
        sdram_dq_oe  = wr_sdram_en && state == ARB_WRITE;
        sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 16'd0;
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
    assign sdram_cke = 1'b1;
endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: randomized and directed scoreboard bench for sdram_arbit against a bus-ownership model
module tb_sdram_arbit;
    logic        sys_clk, sys_rst, init_end;
    logic [3:0]  init_cmd, aref_cmd, write_cmd, read_cmd;
    logic [1:0]  init_ba, aref_ba, write_ba, read_ba;
    logic [12:0] init_addr, aref_addr, write_addr, read_addr;
    logic        aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en;
    logic [15:0] wr_sdram_data;
    logic        aref_en, wr_en, rd_en, sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    sdram_arbit dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .init_cmd(init_cmd), .init_ba(init_ba), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_ba(aref_ba), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end),
        .write_cmd(write_cmd), .write_ba(write_ba), .write_addr(write_addr),
        .wr_sdram_en(wr_sdram_en), .wr_sdram_data(wr_sdram_data),
        .rd_req(rd_req), .rd_end(rd_end),
        .read_cmd(read_cmd), .read_ba(read_ba), .read_addr(read_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en), .sdram_cke(sdram_cke),
        .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n), .sdram_cas_n(sdram_cas_n),
        .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba), .sdram_addr(sdram_addr),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [2:0]  gnt;
        logic        oe;
        logic [15:0] dq;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    // owner of the bus: 0 init engine, 1 nobody (NOP gap), 2 refresh, 3 write, 4 read
    int   owner;
    logic last_rd_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, ncyc, act, exp);
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        case (owner)
            0:       {e.cmd, e.ba, e.addr} = {init_cmd, init_ba, init_addr};
            2:       {e.cmd, e.ba, e.addr} = {aref_cmd, aref_ba, aref_addr};
            3:       {e.cmd, e.ba, e.addr} = {write_cmd, write_ba, write_addr};
            4:       {e.cmd, e.ba, e.addr} = {read_cmd, read_ba, read_addr};
            default: {e.cmd, e.ba, e.addr} = {4'b0111, 2'b11, 13'h1FFF};
        endcase
        e.gnt = owner == 2 ? 3'b100 : owner == 3 ? 3'b010 : owner == 4 ? 3'b001 : 3'b000;
        e.oe  = owner == 3 && wr_sdram_en;
        e.dq  = e.oe ? wr_sdram_data : 16'd0;
        return e;
    endfunction

    task automatic advance();
        int nxt;
        logic take_wr;
        nxt = owner;
`ifdef SDRAM_ARB_RR_EN
        take_wr = wr_req && (!rd_req || last_rd_m);
`else
        take_wr = wr_req;
`endif
        if (owner == 0 && init_end) nxt = 1;
        if (owner == 1) nxt = aref_req ? 2 : take_wr ? 3 : rd_req ? 4 : 1;
        if ((owner == 2 && aref_end) || (owner == 3 && wr_end) || (owner == 4 && rd_end)) nxt = 1;
        if (owner == 1 && nxt == 3) last_rd_m = 1'b0;
        if (owner == 1 && nxt == 4) last_rd_m = 1'b1;
        if (!sys_rst) begin
            nxt = 0;
            last_rd_m = 1'b1;
        end
        owner = nxt;
    endtask

    task automatic cyc();
        q.push_back(expect_now());
        advance();
        @(posedge sys_clk);
        #1;
        ncyc++;
    endtask

    task automatic rnd_bus();
        {init_cmd, aref_cmd, write_cmd, read_cmd} = 16'($urandom);
        {init_ba, aref_ba, write_ba, read_ba} = 8'($urandom);
        init_addr = 13'($urandom);
        aref_addr = 13'($urandom);
        write_addr = 13'($urandom);
        read_addr = 13'($urandom);
        wr_sdram_data = 16'($urandom);
    endtask

    always @(negedge sys_clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("cmd", 32'({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}), 32'(e.cmd));
            chk("ba", 32'(sdram_ba), 32'(e.ba));
            chk("addr", 32'(sdram_addr), 32'(e.addr));
            chk("grant", 32'({aref_en, wr_en, rd_en}), 32'(e.gnt));
            chk("dq_oe", 32'(sdram_dq_oe), 32'(e.oe));
            chk("dq_out", 32'(sdram_dq_out), 32'(e.dq));
            chk("cke", 32'(sdram_cke), 32'd1);
        end
    end

    initial begin
        sys_rst = 1'b0;
        init_end = 1'b0;
        {aref_req, aref_end, wr_req, wr_end, rd_req, rd_end, wr_sdram_en} = '0;
        rnd_bus();
        init_cmd = 4'b0111;
        @(posedge sys_clk);
        #1;
        owner = 0;
        last_rd_m = 1'b1;
        cyc();
        sys_rst = 1'b1;
        repeat (20) begin
            rnd_bus();
            cyc();
        end
        init_end = 1'b1;
        cyc();
        cyc();
        {aref_req, wr_req, rd_req} = 3'b111;
        cyc();
        aref_req = 1'b0;
        cyc();
        cyc();
        aref_end = 1'b1;
        cyc();
        aref_end = 1'b0;
        cyc();
        cyc();
        wr_end = (owner == 3);
        rd_end = (owner == 4);
        cyc();
        {wr_end, rd_end} = 2'b00;
        cyc();
        cyc();
        {wr_end, rd_end, wr_req, rd_req} = 4'b1100;
        cyc();
        {wr_end, rd_end} = 2'b00;
        cyc();
        wr_req = 1'b1;
        cyc();
        wr_req = 1'b0;
        write_cmd = 4'b0011;
        wr_sdram_en = 1'b1;
        wr_sdram_data = 16'hA5A5;
        cyc();
        cyc();
        wr_sdram_en = 1'b0;
        wr_end = 1'b1;
        cyc();
        wr_end = 1'b0;
        cyc();
        wr_req = 1'b1;
        cyc();
        wr_req = 1'b0;
        cyc();
        aref_req = 1'b1;
        cyc();
        cyc();
        wr_end = 1'b1;
        cyc();
        wr_end = 1'b0;
        cyc();
        cyc();
        aref_req = 1'b0;
        aref_end = 1'b1;
        cyc();
        aref_end = 1'b0;
        cyc();
        {wr_req, rd_req} = 2'b11;
        for (int i = 0; i < 60; i++) begin
            rnd_bus();
            wr_sdram_en = 1'($urandom);
            wr_end = owner == 3 && $urandom_range(0, 2) == 0;
            rd_end = owner == 4 && $urandom_range(0, 2) == 0;
            cyc();
        end
        {wr_req, rd_req, wr_end, rd_end, wr_sdram_en} = '0;
        cyc();
        {wr_end, rd_end} = 2'b11;
        cyc();
        {wr_end, rd_end} = 2'b00;
        cyc();
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        cyc();
        sys_rst = 1'b0;
        init_end = 1'b0;
        cyc();
        sys_rst = 1'b1;
        rd_end = 1'b1;
        cyc();
        rd_end = 1'b0;
        cyc();
        cyc();
        init_end = 1'b1;
        cyc();
        cyc();
        for (int i = 0; i < 3000; i++) begin
            rnd_bus();
            sys_rst = $urandom_range(0, 99) != 0;
            init_end = $urandom_range(0, 7) != 0;
            aref_req = $urandom_range(0, 7) == 0;
            {wr_req, rd_req, wr_sdram_en} = 3'($urandom);
            aref_end = $urandom_range(0, 3) == 0;
            wr_end = $urandom_range(0, 3) == 0;
            rd_end = $urandom_range(0, 3) == 0;
            cyc();
        end
        @(negedge sys_clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
